// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types: filter mask, filter indices, scheduler states
package video_pkg;

    localparam int FILT_N = 4;

    typedef logic [FILT_N-1:0] filt_mask_t;

    localparam int FILT_IDX_INVERT = 0;
    localparam int FILT_IDX_GRAY   = 1;
    localparam int FILT_IDX_THRESH = 2;
    localparam int FILT_IDX_BLUR   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } filt_sched_state_t;

endpackage

// File: rtl/vid_sideband_if.sv
// rtl/vid_sideband_if.sv - pixel sideband (data enable, start of frame)
interface vid_sideband_if;
    logic de;
    logic sof;

    modport source (output de, sof);
    modport sink   (input de, sof);
endinterface

// File: rtl/frame_step_cnt.sv
// rtl/frame_step_cnt.sv - frame-start driven hold counter with terminal pulse
module frame_step_cnt #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              fs,
    input  logic [HOLD_W-1:0] hold,
    output logic              term
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W:0]   cnt_inc;
    logic [HOLD_W:0]   hold_eff;

    // Extra bit keeps the compare correct when cnt_q sits at all-ones.
    always_comb begin
        cnt_inc  = {1'b0, cnt_q} + (HOLD_W+1)'(1);
        hold_eff = (hold == '0) ? (HOLD_W+1)'(1) : {1'b0, hold};
        term     = en & fs & (cnt_inc >= hold_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || clr) begin
            cnt_q <= '0;
        end else if (fs) begin
            cnt_q <= term ? '0 : cnt_inc[HOLD_W-1:0];
        end
    end

endmodule

// File: rtl/filt_sched.sv
// rtl/filt_sched.sv - frame-synchronous filter enable scheduler (option: FILT_SCHED_AUTOCYCLE_EN)
module filt_sched
    import video_pkg::*;
#(
    parameter int N_FILT = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vid_sideband_if.sink      sb_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_FILT-1:0] cfg_mask,
    input  logic              cfg_auto,
    input  logic [HOLD_W-1:0] cfg_hold,
    output logic [N_FILT-1:0] filt_en,
    output logic [N_FILT-1:0] active_mask,
    output logic              pending,
    output logic [HOLD_W-1:0] frame_cnt,
    output logic              sof_tick
);

    filt_sched_state_t state_q, state_d;
    logic [N_FILT-1:0] shadow_q;
    logic [N_FILT-1:0] active_q;
    logic [HOLD_W-1:0] frame_q;
    logic              tick_q;
    logic              fs;
    logic              manual_apply;
    logic              auto_step;

    assign fs = sb_in.de & sb_in.sof;

`ifdef FILT_SCHED_AUTOCYCLE_EN
    frame_step_cnt #(.HOLD_W(HOLD_W)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cfg_auto && (state_q == IDLE)),
        .clr   (manual_apply),
        .fs    (fs),
        .hold  (cfg_hold),
        .term  (auto_step)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_auto, cfg_hold};
    assign auto_step  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        manual_apply = 1'b0;
        cfg_ready    = (state_q == IDLE);
        pending      = (state_q == PEND);
        filt_en      = active_q;
        case (state_q)
            IDLE: if (cfg_valid) state_d = PEND;
            PEND: if (fs) begin
                manual_apply = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The frame-start pixel itself must already see the new mask.
        if (manual_apply) begin
            filt_en = shadow_q;
        end else if (auto_step) begin
            filt_en = {active_q[N_FILT-2:0], active_q[N_FILT-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            frame_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= filt_en;
            tick_q   <= fs;
            if (state_q == IDLE && cfg_valid) shadow_q <= cfg_mask;
            if (fs) frame_q <= frame_q + 1'b1;
        end
    end

    assign active_mask = active_q;
    assign frame_cnt   = frame_q;
    assign sof_tick    = tick_q;

endmodule

// File: tb/tb_filt_sched.sv
// tb/tb_filt_sched.sv - self-checking bench for filt_sched
module tb_filt_sched;
    import video_pkg::*;

`ifdef FILT_SCHED_AUTOCYCLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    filt_mask_t cfg_mask = '0;
    logic       cfg_auto = 1'b0;
    logic [7:0] cfg_hold = '0;
    filt_mask_t filt_en;
    filt_mask_t active_mask;
    logic       pending;
    logic [7:0] frame_cnt;
    logic       sof_tick;

    vid_sideband_if sb ();

    int errors = 0;
    int checks = 0;

    filt_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sb_in       (sb.sink),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mask    (cfg_mask),
        .cfg_auto    (cfg_auto),
        .cfg_hold    (cfg_hold),
        .filt_en     (filt_en),
        .active_mask (active_mask),
        .pending     (pending),
        .frame_cnt   (frame_cnt),
        .sof_tick    (sof_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic filt_mask_t rotl(input filt_mask_t m);
        int v;
        v = (int'(m) * 2 + int'(m) / 8) % 16;
        return filt_mask_t'(v);
    endfunction

    // Model: masks waiting for frame start in a queue, frames counted as integers.
    filt_mask_t q[$];
    filt_mask_t m_active = '0;
    int         m_frames = 0;
    bit         m_tick = 1'b0;
    int         m_hold = 0;
    filt_mask_t e_en;
    bit         fs_now, had, step;
    int         h_eff;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_active = '0;
            m_frames = 0;
            m_tick   = 1'b0;
            m_hold   = 0;
        end
        fs_now = rst_n && sb.de && sb.sof;
        had    = (q.size() != 0);
        h_eff  = (cfg_hold == 0) ? 1 : int'(cfg_hold);
        e_en   = m_active;
        step   = 1'b0;
        if (had && fs_now) begin
            e_en = q[0];
        end else if (AUTO && cfg_auto && !had && fs_now && (m_hold + 1 >= h_eff)) begin
            e_en = rotl(m_active);
            step = 1'b1;
        end
        check("m_filt_en", filt_en, e_en);
        check("m_active", active_mask, m_active);
        check("m_pending", pending, had);
        check("m_ready", cfg_ready, !had);
        check("m_frame_cnt", frame_cnt, m_frames % 256);
        check("m_sof_tick", sof_tick, m_tick);
        if (rst_n) begin
            m_tick = fs_now;
            if (fs_now) m_frames++;
            if (had || !cfg_auto || step) m_hold = 0;
            else if (fs_now) m_hold++;
            if (had && fs_now) void'(q.pop_front());
            if (!had && cfg_valid) q.push_back(cfg_mask);
            m_active = e_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input bit de, input bit sof);
        sb.de  = de;
        sb.sof = sof;
        #1;
    endtask

    task automatic blank(input int n);
        repeat (n) begin
            px(1'b1, 1'b0);
            tick();
        end
    endtask

    int auto_exp[8] = '{1, 1, 2, 2, 4, 4, 8, 8};
    int auto0_exp[3] = '{1, 2, 4};

    initial begin
        sb.de  = 1'b0;
        sb.sof = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        blank(3);
        check("rst_filt_en", filt_en, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_frame_cnt", frame_cnt, 0);

        // Mid-frame accept, applied on the sof pixel.
        cfg_valid = 1'b1;
        cfg_mask  = 4'b0001;
        px(1'b1, 1'b0);
        tick();
        cfg_valid = 1'b0;
        px(1'b1, 1'b0);
        check("acc_pending", pending, 1);
        check("acc_ready", cfg_ready, 0);
        check("acc_filt_en", filt_en, 0);
        tick();
        blank(2);
        px(1'b1, 1'b1);
        check("sof_filt_en", filt_en, 4'b0001);
        tick();
        px(1'b1, 1'b0);
        check("post_pending", pending, 0);
        check("post_sof_tick", sof_tick, 1);
        check("post_active", active_mask, 4'b0001);
        check("post_frame_cnt", frame_cnt, 1);
        tick();

        // Handshake coinciding with frame start is deferred a frame.
        cfg_valid = 1'b1;
        cfg_mask  = 4'b0010;
        px(1'b1, 1'b1);
        check("same_filt_en", filt_en, 4'b0001);
        tick();
        cfg_valid = 1'b0;
        px(1'b1, 1'b0);
        check("same_active", active_mask, 4'b0001);
        check("same_pending", pending, 1);
        check("same_frame_cnt", frame_cnt, 2);
        tick();
        blank(2);
        px(1'b0, 1'b1);
        check("nde_filt_en", filt_en, 4'b0001);
        tick();
        px(1'b1, 1'b0);
        check("nde_frame_cnt", frame_cnt, 2);
        check("nde_pending", pending, 1);
        tick();
        px(1'b1, 1'b1);
        check("late_filt_en", filt_en, 4'b0010);
        tick();
        blank(1);

        // Second mask held during PEND is taken only after the apply.
        cfg_valid = 1'b1;
        cfg_mask  = 4'b0100;
        px(1'b1, 1'b0);
        tick();
        cfg_mask = 4'b1000;
        px(1'b1, 1'b0);
        check("hold_ready", cfg_ready, 0);
        check("hold_pending", pending, 1);
        tick();
        blank(1);
        px(1'b1, 1'b1);
        check("hold_filt_en", filt_en, 4'b0100);
        tick();
        px(1'b1, 1'b0);
        check("hold_ready2", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        px(1'b1, 1'b0);
        check("hold_pending2", pending, 1);
        tick();
        blank(2);
        px(1'b1, 1'b1);
        check("hold2_filt_en", filt_en, 4'b1000);
        tick();
        px(1'b1, 1'b1);
        check("rep_filt_en", filt_en, 4'b1000);
        tick();
        px(1'b1, 1'b0);
        check("rep_active", active_mask, 4'b1000);
        check("rep_frame_cnt", frame_cnt, 6);
        tick();

`ifdef FILT_SCHED_AUTOCYCLE_EN
        cfg_auto  = 1'b1;
        cfg_hold  = 8'd2;
        cfg_valid = 1'b1;
        cfg_mask  = 4'b0001;
        px(1'b1, 1'b0);
        tick();
        cfg_valid = 1'b0;
        for (int f = 0; f < 8; f++) begin
            blank(2);
            px(1'b1, 1'b1);
            check($sformatf("auto2_f%0d", f), filt_en, auto_exp[f]);
            tick();
        end
        cfg_hold = 8'd0;
        for (int f = 0; f < 3; f++) begin
            blank(2);
            px(1'b1, 1'b1);
            check($sformatf("auto0_f%0d", f), filt_en, auto0_exp[f]);
            tick();
        end
        cfg_auto = 1'b0;
        blank(2);
`else
        cfg_auto = 1'b1;
        cfg_hold = 8'd1;
        for (int f = 0; f < 3; f++) begin
            blank(2);
            px(1'b1, 1'b1);
            check($sformatf("manual_f%0d", f), filt_en, 4'b1000);
            tick();
        end
        cfg_auto = 1'b0;
        blank(1);
`endif

        // Asynchronous reset while a mask is pending.
        cfg_valid = 1'b1;
        cfg_mask  = 4'b1010;
        px(1'b1, 1'b0);
        tick();
        cfg_valid = 1'b0;
        px(1'b1, 1'b0);
        check("pre_rst_pending", pending, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_filt_en", filt_en, 0);
        check("arst_active", active_mask, 0);
        check("arst_pending", pending, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_sof_tick", sof_tick, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        px(1'b1, 1'b1);
        check("arst_fs_filt_en", filt_en, 0);
        tick();
        px(1'b1, 1'b0);
        check("arst_fs_active", active_mask, 0);
        check("arst_fs_frame_cnt", frame_cnt, 1);
        tick();
        blank(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
